uart_rx_core: RTL and testbench
===============================

# uart_rx_core

UART receiver that deserialises 8-N-1 frames from the board RX pin and hands each byte to the loopback controller through the rx_en_sig / rx_done_sig / rx_data handshake. It sits directly upstream of the control stage. It synchronises the asynchronous line, validates start and stop bits with mid-bit sampling, and reports framing errors separately so bad bytes are never forwarded.

## Interface
- CLK_FREQ, 50_000_000: sysclk frequency in Hz.
- BAUD, 9600: line rate in baud.
- BAUD_DIV, CLK_FREQ/BAUD: sysclk cycles per bit (integer division); must be ≥ 4. Benches may override it directly.
- sysclk  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low; clock: sysclk.
- rx_pin  in  1  asynchronous serial input, idle high.
- rx_en_sig  in  1  receive enable from the controller.
- rx_data  out  8  last good byte, LSB received first.
- rx_done_sig  out  1  one-cycle pulse: rx_data updated with a good byte.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_busy  out  1  high while a frame is in progress (any state other than IDLE).

## Operation
- The 2-flop synchroniser on rx_pin resets to 1. The falling-edge detector compares synchroniser output with a third delayed flop.
- States: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
- IDLE: when rx_en_sig=1 and a falling edge is detected -> START. Clear the baud counter and bit index.
- Baud counter counts 0..BAUD_DIV-1 and wraps. Sample point is count == BAUD_DIV/2 (integer division).
- START: at the sample point, line=0 -> continue (on counter wrap -> DATA). Line=1 -> false start, return to IDLE with no pulse.
- DATA: at each sample point, shift the line into a shift register, LSB first. After bit index 7 wraps -> STOP.
- STOP: at the sample point:
  - line=1 -> load rx_data from the shift register and pulse rx_done_sig.
  - line=0 -> pulse rx_frame_err and leave rx_data unchanged.
  - Either way, go to IDLE in the same cycle. The rest of the stop bit is not waited for. A new falling edge is needed to start again.
- rx_en_sig=0 in any non-IDLE state: abort to IDLE on the next edge, with no pulse and rx_data unchanged.
- rx_en_sig=0 in IDLE: edges are ignored.
- rx_data holds its value until the next good frame. The controller may latch it any number of cycles after rx_done_sig.
- A line held low (break) produces one rx_frame_err, then waits in IDLE for a high-to-low edge.

## Timing
- Reset values: rx_data=8'h00, rx_done_sig=0, rx_frame_err=0, rx_busy=0, state IDLE.
- Reset mid-frame discards the frame. No pulse follows reset release.
- Latency from the synchronised falling edge to rx_done_sig: 9·BAUD_DIV + BAUD_DIV/2 + 1 cycles. Add 2 cycles of synchroniser delay from the rx_pin edge. With parity enabled, add BAUD_DIV.
- rx_done_sig and rx_frame_err are registered and never asserted in the same cycle.
- rx_data changes only in the same cycle that rx_done_sig is asserted.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is 8-E-1. PARITY state sits between DATA and STOP and samples one bit.
  - Output rx_parity_err (1 bit, reset 0) is added.
  - In STOP with a good stop bit and a parity mismatch: pulse rx_parity_err instead of rx_done_sig, and leave rx_data unchanged.
  - A framing error takes priority over a parity error.
- Undefined: 8-N-1, no PARITY state, no rx_parity_err port.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, PARITY);
  - the DATA_W=8 constant;
  - the baud-divisor function CLK_FREQ/BAUD, which uart_tx also uses.
- Sub-module uart_rx_sync contains the 2-flop synchroniser plus the falling-edge detector (outputs rx_s, rx_fall).

## Test plan
Benches override BAUD_DIV=16.
- rx_en_sig=1, send 0x55 8-N-1 -> exactly one rx_done_sig, rx_data=0x55, 9·16+8+1 cycles after the synchronised edge.
- Back-to-back frames 0xA5 then 0x3C with one idle bit between -> two done pulses, rx_data=0xA5 then 0x3C, no errors.
- rx_pin low glitch of 3 cycles -> false start, no pulses, rx_busy back to 0 before cycle 10.
- Frame 0x81 with stop bit 0 -> one rx_frame_err pulse, no rx_done_sig, rx_data keeps its prior value; a following good 0x7E is received correctly.
- rx_en_sig=0 during a whole frame 0xFF -> no pulses. rx_en_sig dropped in DATA -> abort, rx_busy=0 next cycle.
- rst_n asserted at bit 4 of 0x12 -> all outputs 0 immediately; after release, frame 0x34 -> rx_data=0x34.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> rx_parity_err pulse, no rx_done_sig.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive/transmit types, constants and baud divisor helper.
package uart_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_e;
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the RX pin plus falling-edge detector.
// Ports: sysclk/rst_n (async active-low), rx_pin (async line), rx_s (synchronised line), rx_fall (high-to-low edge).
module uart_rx_sync (
  input  logic sysclk,
  input  logic rst_n,
  input  logic rx_pin,
  output logic rx_s,
  output logic rx_fall
);
  logic [2:0] sh_q;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) sh_q <= '1;
    else sh_q <= {sh_q[1:0], rx_pin};
  assign rx_s = sh_q[1];
  assign rx_fall = sh_q[2] & ~sh_q[1];
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8-N-1 UART receiver with mid-bit sampling and separate framing-error reporting.
// Ports: sysclk/rst_n (async active-low), rx_pin (serial in, idle high), rx_en_sig (enable),
//        rx_data (last good byte), rx_done_sig (good-byte pulse), rx_frame_err (bad stop pulse),
//        rx_busy (frame in progress), rx_parity_err (parity pulse, only with UART_RX_PARITY_EN).
// Define UART_RX_PARITY_EN for 8-E-1 frames with a PARITY state and rx_parity_err output.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int BAUD_DIV = baud_div(CLK_FREQ, BAUD)
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              rx_pin,
  input  logic              rx_en_sig,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_done_sig,
  output logic              rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic              rx_parity_err,
`endif
  output logic              rx_busy
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(BAUD_DIV / 2);
`ifdef UART_RX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = STOP;
`endif
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
  logic done_q, done_d, ferr_q, ferr_d;
  logic rx_s, rx_fall, mid, wrap, par_bad;
  uart_rx_sync u_sync (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .rx_pin (rx_pin),
    .rx_s   (rx_s),
    .rx_fall(rx_fall)
  );
  assign mid  = cnt_q == CNT_MID;
  assign wrap = cnt_q == CNT_MAX;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
  // Even parity: the received parity bit must equal the XOR of the data bits.
  assign par_bad = par_q != ^sh_q;
`else
  assign par_bad = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (state_q == IDLE) begin
      cnt_d = '0;
      idx_d = '0;
      state_d = (rx_en_sig && rx_fall) ? START : IDLE;
    end else if (!rx_en_sig) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        START: state_d = (mid && rx_s) ? IDLE : wrap ? DATA : START;
        DATA: begin
          sh_d = mid ? {rx_s, sh_q[DATA_W-1:1]} : sh_q;
          idx_d = wrap ? idx_q + 3'd1 : idx_q;
          state_d = (wrap && idx_q == 3'd7) ? AFTER_DATA : DATA;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          par_d = mid ? rx_s : par_q;
          state_d = wrap ? STOP : PARITY;
        end
`endif
        STOP: if (mid) begin
          // Decide at mid-stop and return to IDLE at once; the tail of the stop bit is not waited for.
          state_d = IDLE;
          ferr_d  = !rx_s;
          done_d  = rx_s && !par_bad;
          data_d  = done_d ? sh_q : data_q;
`ifdef UART_RX_PARITY_EN
          perr_d  = rx_s && par_bad;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  assign rx_data      = data_q;
  assign rx_done_sig  = done_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core at BAUD_DIV=16.
module tb_uart_rx_core;
  localparam int B = 16;
`ifdef UART_RX_PARITY_EN
  localparam longint LAT = 9 * B + B / 2 + 1 + B;
`else
  localparam longint LAT = 9 * B + B / 2 + 1;
`endif
  logic sysclk = 1'b0, rst_n = 1'b0, rx_pin = 1'b1, rx_en_sig = 1'b1;
  logic [7:0] rx_data;
  logic rx_done_sig, rx_frame_err, rx_busy, rx_parity_err;
  int checks = 0, errors = 0;
  int n_done = 0, n_ferr = 0, n_perr = 0;
  longint cyc = 0, cyc_busy = 0, cyc_done = 0;
  logic busy_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic [7:0] exp_b;
  logic [7:0] exp_q[$];

  uart_rx_core #(.BAUD_DIV(B)) dut (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .rx_pin       (rx_pin),
    .rx_en_sig    (rx_en_sig),
    .rx_data      (rx_data),
    .rx_done_sig  (rx_done_sig),
    .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_busy      (rx_busy)
  );
`ifndef UART_RX_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (rx_busy && !busy_prev) cyc_busy = cyc;
    busy_prev = rx_busy;
    if (rx_done_sig || rx_frame_err) begin
      checks++;
      if (rx_done_sig && rx_frame_err) begin
        errors++;
        $display("FAIL pulse_overlap: done=%b frame_err=%b, required not both", rx_done_sig, rx_frame_err);
      end
    end
    if (rx_frame_err) n_ferr++;
    if (rx_parity_err) n_perr++;
    if (rx_done_sig) begin
      n_done++;
      cyc_done = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: rx_data=%h with rx_done_sig, required no pulse", rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx_data !== exp_b) begin
          errors++;
          $display("FAIL sb_data: rx_data=%h, required %h", rx_data, exp_b);
        end
      end
    end else if (rst_n && rx_data !== data_prev) begin
      checks++;
      errors++;
      $display("FAIL data_change: rx_data %h -> %h without rx_done_sig", data_prev, rx_data);
    end
    data_prev = rx_data;
  end

  task automatic idle(input int n);
    rx_pin = 1'b1;
    repeat (n) @(negedge sysclk);
  endtask

  task automatic drive_bit(input logic b);
    rx_pin = b;
    repeat (B) @(negedge sysclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop);
    rx_pin = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge sysclk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h, required 00", rx_data); end
    checks++; if (rx_done_sig !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", rx_done_sig); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b, required 0", rx_frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", rx_busy); end
    rst_n = 1'b1;
    idle(4);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b, required 0", rx_busy); end
  endtask

  task automatic test_basic;
    int d0 = n_done;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle(4);
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL basic_count: got %0d pulses, required 1", n_done - d0); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL basic_data: got %h, required 55", rx_data); end
    checks++; if (cyc_done - cyc_busy != LAT) begin errors++; $display("FAIL basic_latency: got %0d, required %0d", cyc_done - cyc_busy, LAT); end
  endtask

  task automatic test_back_to_back;
    int d0 = n_done, f0 = n_ferr;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(B);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(4);
    checks++; if (n_done - d0 != 2) begin errors++; $display("FAIL b2b_count: got %0d pulses, required 2", n_done - d0); end
    checks++; if (n_ferr != f0) begin errors++; $display("FAIL b2b_ferr: got %0d errors, required 0", n_ferr - f0); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL b2b_data: got %h, required 3C", rx_data); end
  endtask

  task automatic test_glitch;
    int d0 = n_done, f0 = n_ferr, k = 0;
    rx_pin = 1'b0;
    repeat (3) @(negedge sysclk);
    rx_pin = 1'b1;
    while (!rx_busy && k < 8) begin @(negedge sysclk); k++; end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_start: busy=%b, required 1", rx_busy); end
    k = 0;
    while (rx_busy && k < 20) begin @(negedge sysclk); k++; end
    checks++; if (k >= 10) begin errors++; $display("FAIL glitch_busy: busy low after %0d cycles, required < 10", k); end
    idle(2 * B);
    checks++; if (n_done != d0 || n_ferr != f0) begin errors++; $display("FAIL glitch_pulses: done=%0d ferr=%0d, required 0 0", n_done - d0, n_ferr - f0); end
  endtask

  task automatic test_frame_err;
    int d0 = n_done, f0 = n_ferr;
    send_frame(8'h81, 1'b0);
    idle(B);
    checks++; if (n_ferr - f0 != 1) begin errors++; $display("FAIL ferr_count: got %0d, required 1", n_ferr - f0); end
    checks++; if (n_done != d0) begin errors++; $display("FAIL ferr_done: got %0d pulses, required 0", n_done - d0); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h, required 3C", rx_data); end
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(4);
    checks++; if (rx_data !== 8'h7E || n_done - d0 != 1) begin errors++; $display("FAIL ferr_recover: data=%h pulses=%0d, required 7E 1", rx_data, n_done - d0); end
  endtask

  task automatic test_disable;
    int d0 = n_done, f0 = n_ferr;
    rx_en_sig = 1'b0;
    send_frame(8'hFF, 1'b1);
    idle(4);
    checks++; if (n_done != d0 || n_ferr != f0 || rx_busy !== 1'b0) begin errors++; $display("FAIL dis_frame: done=%0d ferr=%0d busy=%b, required 0 0 0", n_done - d0, n_ferr - f0, rx_busy); end
    rx_en_sig = 1'b1;
    idle(B);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL dis_busy_data: busy=%b, required 1", rx_busy); end
    rx_en_sig = 1'b0;
    @(negedge sysclk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL dis_abort: busy=%b, required 0", rx_busy); end
    rx_pin = 1'b1;
    rx_en_sig = 1'b1;
    idle(2 * B);
    checks++; if (n_done != d0 || n_ferr != f0 || rx_data !== 8'h7E) begin errors++; $display("FAIL dis_after: done=%0d ferr=%0d data=%h, required 0 0 7E", n_done - d0, n_ferr - f0, rx_data); end
  endtask

  task automatic test_reset_mid;
    int d0, f0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 1);
    rst_n = 1'b0;
    #1;
    checks++; if (rx_data !== 8'h00 || rx_done_sig !== 1'b0 || rx_frame_err !== 1'b0 || rx_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: data=%h done=%b ferr=%b busy=%b, required 00 0 0 0", rx_data, rx_done_sig, rx_frame_err, rx_busy);
    end
    rx_pin = 1'b1;
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    d0 = n_done;
    f0 = n_ferr;
    idle(B);
    checks++; if (n_done != d0 || n_ferr != f0) begin errors++; $display("FAIL rstmid_pulse: done=%0d ferr=%0d after release, required 0 0", n_done - d0, n_ferr - f0); end
    exp_q.push_back(8'h34);
    send_frame(8'h34, 1'b1);
    idle(4);
    checks++; if (rx_data !== 8'h34) begin errors++; $display("FAIL rstmid_data: got %h, required 34", rx_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int d0 = n_done, p0 = n_perr;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i < 3);
    drive_bit(1'b0);
    drive_bit(1'b1);
    idle(4);
    checks++; if (n_perr - p0 != 1) begin errors++; $display("FAIL par_err: got %0d pulses, required 1", n_perr - p0); end
    checks++; if (n_done != d0 || rx_data !== 8'h34) begin errors++; $display("FAIL par_done: done=%0d data=%h, required 0 34", n_done - d0, rx_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_disable();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_pending: %0d bytes never received, required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
